// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: N-to-1 MemoryBus arbiter between the ray-tracing cores
// and the shared memory slave.
//   clk_in, rst_in          clock, asynchronous active-high reset
//   m_ms*                   flattened per-master request channels (ID/addr/data/write/valid, ready out)
//   m_sm*                   flattened per-master response channels (ID/data/valid out, ready in)
//   s_ms*                   registered request towards the slave
//   s_sm*                   response from the slave, routed by low ID bits
module memory_bus_arbiter #(
  parameter int N_MASTERS       = 4,
  parameter int MASTER_ID_WIDTH = 8,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 16
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [N_MASTERS*MASTER_ID_WIDTH-1:0] m_msID,
  input  logic [N_MASTERS*ADDRESS_WIDTH-1:0]   m_msAddress,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]      m_msData,
  input  logic [N_MASTERS-1:0]                 m_msWrite,
  input  logic [N_MASTERS-1:0]                 m_msValid,
  output logic [N_MASTERS-1:0]                 m_msReady,
  output logic [N_MASTERS*MASTER_ID_WIDTH-1:0] m_smID,
  output logic [N_MASTERS*DATA_WIDTH-1:0]      m_smData,
  output logic [N_MASTERS-1:0]                 m_smValid,
  input  logic [N_MASTERS-1:0]                 m_smReady,
  output logic [MASTER_ID_WIDTH-1:0]           s_msID,
  output logic [ADDRESS_WIDTH-1:0]             s_msAddress,
  output logic [DATA_WIDTH-1:0]                s_msData,
  output logic                                 s_msWrite,
  output logic                                 s_msValid,
  input  logic                                 s_msReady,
  input  logic [MASTER_ID_WIDTH-1:0]           s_smID,
  input  logic [DATA_WIDTH-1:0]                s_smData,
  input  logic                                 s_smValid,
  output logic                                 s_smReady
);

  localparam int          PORT_BITS = $clog2(N_MASTERS);
  localparam int unsigned N         = N_MASTERS;

  logic [MASTER_ID_WIDTH-1:0] ms_id   [N_MASTERS];
  logic [ADDRESS_WIDTH-1:0]   ms_addr [N_MASTERS];
  logic [DATA_WIDTH-1:0]      ms_data [N_MASTERS];

  logic [PORT_BITS-1:0]       rr_ptr;
  logic [PORT_BITS-1:0]       grant;
  logic [PORT_BITS-1:0]       rr_next;
  logic                       grant_valid;
  logic                       req_free;
  logic [MASTER_ID_WIDTH-1:0] grant_id;
  int unsigned                scan_idx;

  logic                       rsp_valid;
  logic [PORT_BITS-1:0]       rsp_dst;
  logic [MASTER_ID_WIDTH-1:0] rsp_id;
  logic [DATA_WIDTH-1:0]      rsp_data;
  logic                       dst_ok;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_lane
    assign ms_id[i]   = m_msID[i*MASTER_ID_WIDTH +: MASTER_ID_WIDTH];
    assign ms_addr[i] = m_msAddress[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign ms_data[i] = m_msData[i*DATA_WIDTH +: DATA_WIDTH];
    assign m_smID[i*MASTER_ID_WIDTH +: MASTER_ID_WIDTH] = rsp_id;
    assign m_smData[i*DATA_WIDTH +: DATA_WIDTH]         = rsp_data;
  end

  // Response IDs whose port field exceeds N_MASTERS-1 only exist when N is
  // not a power of two; such responses are consumed without a destination.
  if ((1 << PORT_BITS) == N_MASTERS) begin : g_pow2
    assign dst_ok = 1'b1;
  end else begin : g_npow2
    assign dst_ok = (s_smID[PORT_BITS-1:0] < PORT_BITS'(N_MASTERS));
  end

  // Round-robin scan starting at rr_ptr, wrapping modulo N.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    scan_idx    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_idx = int'(rr_ptr) + i;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!grant_valid && m_msValid[scan_idx]) begin
        grant_valid = 1'b1;
        grant       = PORT_BITS'(scan_idx);
      end
    end
  end

  always_comb begin
    req_free  = !s_msValid || s_msReady;
    m_msReady = '0;
    if (req_free && grant_valid) m_msReady[grant] = 1'b1;
    rr_next   = (grant == PORT_BITS'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
    grant_id  = ms_id[grant];
    grant_id[PORT_BITS-1:0] = grant;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s_msValid   <= 1'b0;
      s_msID      <= '0;
      s_msAddress <= '0;
      s_msData    <= '0;
      s_msWrite   <= 1'b0;
      rr_ptr      <= '0;
    end else if (req_free) begin
      s_msValid <= grant_valid;
      if (grant_valid) begin
        s_msID      <= grant_id;
        s_msAddress <= ms_addr[grant];
        s_msData    <= ms_data[grant];
        s_msWrite   <= m_msWrite[grant];
        rr_ptr      <= rr_next;
      end
    end
  end

  always_comb begin
    s_smReady = !rsp_valid || m_smReady[rsp_dst];
    m_smValid = '0;
    if (rsp_valid) m_smValid[rsp_dst] = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rsp_valid <= 1'b0;
      rsp_dst   <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (s_smReady) begin
      rsp_valid <= s_smValid && dst_ok;
      if (s_smValid) begin
        rsp_dst  <= s_smID[PORT_BITS-1:0];
        rsp_id   <= s_smID;
        rsp_data <= s_smData;
      end
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
module tb_memory_bus_arbiter;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic [31:0]  m_msID;
  logic [127:0] m_msAddress;
  logic [63:0]  m_msData;
  logic [3:0]   m_msWrite, m_msValid, m_msReady;
  logic [31:0]  m_smID;
  logic [63:0]  m_smData;
  logic [3:0]   m_smValid, m_smReady;
  logic [7:0]   s_msID;
  logic [31:0]  s_msAddress;
  logic [15:0]  s_msData;
  logic         s_msWrite, s_msValid, s_msReady;
  logic [7:0]   s_smID;
  logic [15:0]  s_smData;
  logic         s_smValid, s_smReady;

  int vectors    = 0;
  int miscompares = 0;

  memory_bus_arbiter #(
    .N_MASTERS(4), .MASTER_ID_WIDTH(8), .ADDRESS_WIDTH(32), .DATA_WIDTH(16)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .m_msID(m_msID), .m_msAddress(m_msAddress), .m_msData(m_msData),
    .m_msWrite(m_msWrite), .m_msValid(m_msValid), .m_msReady(m_msReady),
    .m_smID(m_smID), .m_smData(m_smData), .m_smValid(m_smValid), .m_smReady(m_smReady),
    .s_msID(s_msID), .s_msAddress(s_msAddress), .s_msData(s_msData),
    .s_msWrite(s_msWrite), .s_msValid(s_msValid), .s_msReady(s_msReady),
    .s_smID(s_smID), .s_smData(s_smData), .s_smValid(s_smValid), .s_smReady(s_smReady)
  );

  always #5 clk_in = ~clk_in;

  task automatic nx();
    @(posedge clk_in);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_in);
  endtask

  task automatic idle_inputs();
    m_msID = '0; m_msAddress = '0; m_msData = '0; m_msWrite = '0; m_msValid = '0;
    m_smReady = '0; s_msReady = 1'b0;
    s_smID = '0; s_smData = '0; s_smValid = 1'b0;
  endtask

  task automatic set_master(input int p, input logic [7:0] id, input logic [31:0] addr,
                            input logic [15:0] data, input logic wr);
    m_msID[p*8 +: 8]        = id;
    m_msAddress[p*32 +: 32] = addr;
    m_msData[p*16 +: 16]    = data;
    m_msWrite[p]            = wr;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_in = 1'b1;
    nx();
    nx();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    smp();
    vectors++;
    if ({s_msValid, m_smValid, m_msReady} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_valids got s_msValid=%b m_smValid=%b m_msReady=%b exp all 0",
               s_msValid, m_smValid, m_msReady);
    end
    vectors++;
    if ({s_msID, s_msAddress, s_msData, s_msWrite} !== 57'b0 || m_smData !== 64'b0 || m_smID !== 32'b0) begin
      miscompares++;
      $display("FAIL reset_fields got s_msID=%h s_msAddress=%h m_smData=%h exp 0",
               s_msID, s_msAddress, m_smData);
    end
    vectors++;
    if (s_smReady !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_smready got %b exp 1", s_smReady);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    logic [7:0] exp_id;
    int g;
    apply_reset();
    for (int p = 0; p < 4; p++)
      set_master(p, 8'hC3 + 8'(p * 16), 32'h1000 + 32'(p), 16'hD000 + 16'(p), 1'(p));
    m_msValid = 4'b1111;
    s_msReady = 1'b1;
    for (int k = 0; k < 7; k++) begin
      smp();
      exp_rdy = 4'b0001 << (k % 4);
      vectors++;
      if (m_msReady !== exp_rdy) begin
        miscompares++;
        $display("FAIL rr_grant[%0d] got %b exp %b", k, m_msReady, exp_rdy);
      end
      if (k == 0) begin
        vectors++;
        if (s_msValid !== 1'b0) begin
          miscompares++;
          $display("FAIL rr_latency got s_msValid=%b exp 0", s_msValid);
        end
      end else begin
        g = (k - 1) % 4;
        exp_id = ((8'hC3 + 8'(g * 16)) & 8'hFC) | 8'(g);
        vectors++;
        if (s_msValid !== 1'b1 || s_msID !== exp_id || s_msAddress !== 32'h1000 + 32'(g)
            || s_msData !== 16'hD000 + 16'(g) || s_msWrite !== 1'(g)) begin
          miscompares++;
          $display("FAIL rr_fwd[%0d] got v=%b id=%h addr=%h data=%h w=%b exp v=1 id=%h addr=%h",
                   k, s_msValid, s_msID, s_msAddress, s_msData, s_msWrite, exp_id, 32'h1000 + 32'(g));
        end
      end
      nx();
    end
    m_msValid = 4'b0000;
    smp();
    vectors++;
    if (s_msValid !== 1'b1 || s_msAddress !== 32'h1002) begin
      miscompares++;
      $display("FAIL rr_last got v=%b addr=%h exp v=1 addr=00001002", s_msValid, s_msAddress);
    end
    nx();
    smp();
    vectors++;
    if (s_msValid !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_drain got s_msValid=%b exp 0", s_msValid);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    set_master(2, 8'hA5, 32'h100, 16'h1234, 1'b1);
    m_msValid = 4'b0100;
    smp();
    vectors++;
    if (m_msReady !== 4'b0100) begin
      miscompares++;
      $display("FAIL stall_grant got %b exp 0100", m_msReady);
    end
    nx();
    for (int c = 0; c < 3; c++) begin
      smp();
      vectors++;
      if (s_msValid !== 1'b1 || s_msID !== 8'hA6 || s_msAddress !== 32'h100
          || s_msData !== 16'h1234 || s_msWrite !== 1'b1 || m_msReady !== 4'b0000) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got v=%b id=%h addr=%h data=%h w=%b rdy=%b exp 1 a6 100 1234 1 0000",
                 c, s_msValid, s_msID, s_msAddress, s_msData, s_msWrite, m_msReady);
      end
      nx();
    end
    s_msReady = 1'b1;
    smp();
    vectors++;
    if (m_msReady !== 4'b0100) begin
      miscompares++;
      $display("FAIL stall_release got %b exp 0100", m_msReady);
    end
    nx();
    m_msValid = 4'b0000;
    smp();
    vectors++;
    if (s_msValid !== 1'b1 || s_msID !== 8'hA6) begin
      miscompares++;
      $display("FAIL stall_second got v=%b id=%h exp v=1 id=a6", s_msValid, s_msID);
    end
    nx();
    smp();
    vectors++;
    if (s_msValid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_empty got %b exp 0", s_msValid);
    end
  endtask

  task automatic test_rr_skip();
    apply_reset();
    s_msReady = 1'b1;
    set_master(0, 8'h10, 32'h2000, 16'h0000, 1'b0);
    set_master(3, 8'h30, 32'h2003, 16'h0003, 1'b0);
    m_msValid = 4'b0001;
    nx();
    m_msValid = 4'b1001;
    smp();
    vectors++;
    if (m_msReady !== 4'b1000) begin
      miscompares++;
      $display("FAIL skip_first got %b exp 1000", m_msReady);
    end
    nx();
    smp();
    vectors++;
    if (m_msReady !== 4'b0001 || s_msID !== 8'h33) begin
      miscompares++;
      $display("FAIL skip_wrap got rdy=%b id=%h exp rdy=0001 id=33", m_msReady, s_msID);
    end
    nx();
    m_msValid = 4'b0000;
    smp();
    vectors++;
    if (s_msID !== 8'h10 || s_msAddress !== 32'h2000) begin
      miscompares++;
      $display("FAIL skip_fwd got id=%h addr=%h exp id=10 addr=00002000", s_msID, s_msAddress);
    end
  endtask

  task automatic test_response();
    apply_reset();
    s_smID = 8'h03; s_smData = 16'hBEEF; s_smValid = 1'b1;
    nx();
    s_smID = 8'h01; s_smData = 16'h1111;
    for (int c = 0; c < 2; c++) begin
      smp();
      vectors++;
      if (m_smValid !== 4'b1000 || m_smData[63:48] !== 16'hBEEF || m_smID[31:24] !== 8'h03
          || s_smReady !== 1'b0) begin
        miscompares++;
        $display("FAIL rsp_hold[%0d] got v=%b data=%h id=%h rdy=%b exp 1000 beef 03 0",
                 c, m_smValid, m_smData[63:48], m_smID[31:24], s_smReady);
      end
      nx();
    end
    m_smReady = 4'b1000;
    smp();
    vectors++;
    if (s_smReady !== 1'b1) begin
      miscompares++;
      $display("FAIL rsp_release got %b exp 1", s_smReady);
    end
    nx();
    s_smValid = 1'b0;
    m_smReady = 4'b0000;
    smp();
    vectors++;
    if (m_smValid !== 4'b0010 || m_smData[31:16] !== 16'h1111 || s_smReady !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp_refill got v=%b data=%h rdy=%b exp 0010 1111 0", m_smValid, m_smData[31:16], s_smReady);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    m_smReady = 4'b1111;
    s_smID = 8'h01; s_smData = 16'hA001; s_smValid = 1'b1;
    nx();
    s_smID = 8'h00; s_smData = 16'hA000;
    smp();
    vectors++;
    if (m_smValid !== 4'b0010 || m_smData[31:16] !== 16'hA001 || s_smReady !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first got v=%b data=%h rdy=%b exp 0010 a001 1", m_smValid, m_smData[31:16], s_smReady);
    end
    nx();
    s_smValid = 1'b0;
    smp();
    vectors++;
    if (m_smValid !== 4'b0001 || m_smData[15:0] !== 16'hA000) begin
      miscompares++;
      $display("FAIL b2b_second got v=%b data=%h exp 0001 a000", m_smValid, m_smData[15:0]);
    end
    nx();
    smp();
    vectors++;
    if (m_smValid !== 4'b0000) begin
      miscompares++;
      $display("FAIL b2b_empty got %b exp 0000", m_smValid);
    end
  endtask

  task automatic test_reset_mid_traffic();
    apply_reset();
    set_master(1, 8'h44, 32'h3001, 16'h5555, 1'b1);
    m_msValid = 4'b0010;
    s_smID = 8'h02; s_smData = 16'h7777; s_smValid = 1'b1;
    nx();
    m_msValid = 4'b0000;
    s_smValid = 1'b0;
    smp();
    vectors++;
    if (s_msValid !== 1'b1 || m_smValid !== 4'b0100) begin
      miscompares++;
      $display("FAIL mid_full got s_msValid=%b m_smValid=%b exp 1 0100", s_msValid, m_smValid);
    end
    #2;
    rst_in = 1'b1;
    #1;
    vectors++;
    if (s_msValid !== 1'b0 || m_smValid !== 4'b0000 || s_msID !== 8'h00 || m_smData !== 64'b0) begin
      miscompares++;
      $display("FAIL mid_async got s_msValid=%b m_smValid=%b s_msID=%h exp 0 0000 00",
               s_msValid, m_smValid, s_msID);
    end
    nx();
    rst_in = 1'b0;
    m_msValid = 4'b1110;
    s_msReady = 1'b1;
    smp();
    vectors++;
    if (m_msReady !== 4'b0010) begin
      miscompares++;
      $display("FAIL mid_rrptr got %b exp 0010", m_msReady);
    end
    nx();
    m_msValid = 4'b0000;
  endtask

  initial begin
    rst_in = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_stall();
    test_rr_skip();
    test_response();
    test_back_to_back();
    test_reset_mid_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
